button_event: RTL and testbench

//  Consumes the debounced button level and turns it into one-cycle events: press, release,

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event_tick_gen.sv | 35 +++
 rtl/button_event.sv | 148 ++++++++++++++
 tb/tb_button_event.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types and default timing for the button event stage.
// The default tick and threshold values are also used by the board top.
package button_event_pkg;

    // Press-tracking states of the event FSM.
    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } btn_state_t;

    // Defaults for a 50 MHz clock and a 1 ms tick.
    localparam int DEF_TICK_DIV           = 50000;
    localparam int DEF_LONG_TICKS         = 1000;
    localparam int DEF_REPEAT_DELAY_TICKS = 500;
    localparam int DEF_REPEAT_RATE_TICKS  = 100;
    localparam int DEF_CNT_W              = 16;

endpackage

// File: rtl/button_event_tick_gen.sv
// Tick prescaler for button_event.
// It raises tick for one clk when the count reaches TICK_DIV-1 and then wraps to 0.
// A synchronous clear restarts the count, which makes the first tick land exactly
// TICK_DIV clks after the clear.
module tick_gen
    import button_event_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    // Prescaler count: restarts on clear and wraps after the terminal value.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/button_event.sv
// Button event generator.
// Turns the debounced button level into one-cycle press, release, short-click and
// long-press events, plus an optional auto-repeat strobe.
// Optional feature: define AUTO_REPEAT_EN to build the auto-repeat countdown;
// without it repeat_pulse is tied low and no repeat logic exists.
// All outputs are registered; each event appears one clk after the edge is sampled.
module button_event
    import button_event_pkg::*;
#(
    parameter int TICK_DIV           = DEF_TICK_DIV,
    parameter int LONG_TICKS         = DEF_LONG_TICKS,
    parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             short_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] hold_ticks
);

    // Reject parameter sets the counters cannot represent.
    if (TICK_DIV < 2 || LONG_TICKS < 1 || LONG_TICKS >= (1 << CNT_W) ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_DELAY_TICKS >= (1 << CNT_W) ||
        REPEAT_RATE_TICKS < 1 || REPEAT_RATE_TICKS >= (1 << CNT_W)) begin : g_param_check
        $error("button_event: tick/threshold parameters out of range");
    end

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_TICKS);

    btn_state_t       state;
    logic             prev_level;
    logic             rise;
    logic             fall;
    logic             tick;
    logic [CNT_W-1:0] ticks_inc;

    assign rise = btn_level & ~prev_level;
    assign fall = ~btn_level & prev_level;

    // Saturating increment: hold_ticks sticks at all-ones instead of wrapping.
    assign ticks_inc = (hold_ticks == '1) ? hold_ticks : hold_ticks + CNT_W'(1);

    // The prescaler restarts on every press so tick phase is relative to press_pulse.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rise),
        .tick    (tick)
    );

    // Event FSM: edge detection, hold timing and all registered event outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            prev_level    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            held          <= 1'b0;
            hold_ticks    <= '0;
        end else begin
            prev_level    <= btn_level;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        hold_ticks  <= '0;
                    end
                end
                PRESSED: begin
                    // A fall beats a coincident tick, so a release on the threshold tick
                    // is still a short click and hold_ticks keeps its pre-tick value.
                    if (fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (tick) begin
                        hold_ticks <= ticks_inc;
                        if (ticks_inc == LONG_T) begin
                            state      <= LONG;
                            long_pulse <= 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (tick) begin
                        hold_ticks <= ticks_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_T = CNT_W'(REPEAT_DELAY_TICKS);
    localparam logic [CNT_W-1:0] RATE_T  = CNT_W'(REPEAT_RATE_TICKS);

    // Ticks left until the next repeat strobe; independent of hold_ticks saturation.
    logic [CNT_W-1:0] repeat_left;

    // Auto-repeat countdown: reloaded on press, strobes on each expiry while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            repeat_left  <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (rise) begin
                repeat_left <= DELAY_T;
            end else if (state != IDLE && !fall && tick) begin
                if (repeat_left == CNT_W'(1)) begin
                    repeat_pulse <= 1'b1;
                    repeat_left  <= RATE_T;
                end else begin
                    repeat_left <= repeat_left - CNT_W'(1);
                end
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event (TICK_DIV=4, LONG_TICKS=5, REPEAT_DELAY_TICKS=3,
// REPEAT_RATE_TICKS=2). A wide-counter instance covers the event timing and a
// CNT_W=3 instance covers hold_ticks saturation. Expected events are queued when a
// press is driven and popped as the DUT pulses appear.
module tb_button_event;

    localparam int TD = 4;
    localparam int LT = 5;
    localparam int RD = 3;
    localparam int RR = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_a = 1'b0;
    logic        btn_s = 1'b0;

    logic        press_a, release_a, short_a, long_a, repeat_a, held_a;
    logic [15:0] hold_a;
    logic        press_s, release_s, short_s, long_s, repeat_s, held_s;
    logic [2:0]  hold_s;

    button_event #(
        .TICK_DIV (TD), .LONG_TICKS (LT), .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS (RR), .CNT_W (16)
    ) dut (
        .clk (clk), .reset_n (reset_n), .btn_level (btn_a),
        .press_pulse (press_a), .release_pulse (release_a), .short_pulse (short_a),
        .long_pulse (long_a), .repeat_pulse (repeat_a), .held (held_a),
        .hold_ticks (hold_a)
    );

    button_event #(
        .TICK_DIV (TD), .LONG_TICKS (LT), .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS (RR), .CNT_W (3)
    ) dut_s (
        .clk (clk), .reset_n (reset_n), .btn_level (btn_s),
        .press_pulse (press_s), .release_pulse (release_s), .short_pulse (short_s),
        .long_pulse (long_s), .repeat_pulse (repeat_s), .held (held_s),
        .hold_ticks (hold_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_SHORT, EV_LONG, EV_REPEAT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       ticks;
    } ev_t;

    ev_t q_a[$];
    ev_t q_s[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int sel, input ev_kind_t k, input int c, input int t);
        ev_t e;
        e.kind  = k;
        e.cyc   = c;
        e.ticks = t;
        if (sel == 0) q_a.push_back(e);
        else          q_s.push_back(e);
    endtask

    // Compare one observed pulse against the oldest expected event.
    task automatic take(input int sel, input ev_kind_t k, input int ticks);
        ev_t   e;
        string tag;
        tag = $sformatf("%s[%0d]@%0d", k.name(), sel, cyc);
        if ((sel == 0 && q_a.size() == 0) || (sel != 0 && q_s.size() == 0)) begin
            check({tag, " unexpected"}, 1, 0);
            return;
        end
        e = (sel == 0) ? q_a.pop_front() : q_s.pop_front();
        check({tag, " kind"}, int'(k), int'(e.kind));
        if (k == e.kind) begin
            check({tag, " cycle"}, cyc, e.cyc);
            check({tag, " hold_ticks"}, ticks, e.ticks);
        end
    endtask

    // Monitor both DUTs away from the rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (press_a)   take(0, EV_PRESS,   int'(hold_a));
            if (release_a) take(0, EV_RELEASE, int'(hold_a));
            if (short_a)   take(0, EV_SHORT,   int'(hold_a));
            if (long_a)    take(0, EV_LONG,    int'(hold_a));
            if (repeat_a)  take(0, EV_REPEAT,  int'(hold_a));
            if (press_s)   take(1, EV_PRESS,   int'(hold_s));
            if (release_s) take(1, EV_RELEASE, int'(hold_s));
            if (short_s)   take(1, EV_SHORT,   int'(hold_s));
            if (long_s)    take(1, EV_LONG,    int'(hold_s));
            if (repeat_s)  take(1, EV_REPEAT,  int'(hold_s));
        end
    end

    // Expected events for a press visible at cycle p whose release is visible at p+h.
    // Ticks land at p+TD*k; the one coinciding with the release is lost to the fall.
    task automatic expect_hold(input int sel, input int p, input int h);
        int n;
        int sat;
        n   = (h - 1) / TD;
        sat = (sel == 0) ? 65535 : 7;
        push(sel, EV_PRESS, p, 0);
        for (int k = 1; k <= n; k++) begin
            if (k == LT) push(sel, EV_LONG, p + TD * k, (k < sat) ? k : sat);
`ifdef AUTO_REPEAT_EN
            if (k >= RD && (k - RD) % RR == 0) push(sel, EV_REPEAT, p + TD * k, (k < sat) ? k : sat);
`endif
        end
        push(sel, EV_RELEASE, p + h, (n < sat) ? n : sat);
        if (n < LT) push(sel, EV_SHORT, p + h, (n < sat) ? n : sat);
    endtask

    // Hold the button for h sampled cycles, then leave it low for gap cycles.
    task automatic run_press(input int sel, input int h, input int gap);
        int p;
        if (sel == 0) btn_a = 1'b1;
        else          btn_s = 1'b1;
        p = cyc + 1;
        expect_hold(sel, p, h);
        repeat (h) @(negedge clk);
        check($sformatf("held_before_release[%0d]", sel), (sel == 0) ? int'(held_a) : int'(held_s), 1);
        if (sel == 0) btn_a = 1'b0;
        else          btn_s = 1'b0;
        @(negedge clk);
        if (gap >= 2) begin
            @(negedge clk);
            check($sformatf("held_after_release[%0d]", sel), (sel == 0) ? int'(held_a) : int'(held_s), 0);
            check($sformatf("pending_events[%0d]", sel), (sel == 0) ? q_a.size() : q_s.size(), 0);
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_press", int'(press_a), 0);
        check("rst_release", int'(release_a), 0);
        check("rst_short", int'(short_a), 0);
        check("rst_long", int'(long_a), 0);
        check("rst_repeat", int'(repeat_a), 0);
        check("rst_held", int'(held_a), 0);
        check("rst_hold_ticks", int'(hold_a), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_press(0, 5, 4);    // short click, hold_ticks=1
        run_press(0, 30, 4);   // long press, release only
        run_press(0, 40, 4);   // long press with repeat window
        run_press(0, 20, 4);   // fall on the 5th tick: short, hold_ticks=4
        run_press(0, 21, 4);   // fall one cycle after the long threshold
        run_press(0, 6, 1);    // back-to-back: one low cycle, then a new press
        run_press(0, 9, 4);

        // Reset mid-press, level still high when reset releases
        btn_a = 1'b1;
        push(0, EV_PRESS, cyc + 1, 0);
        repeat (7) @(negedge clk);
        check("pre_reset_hold_ticks", int'(hold_a), 1);
        check("pre_reset_held", int'(held_a), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_held", int'(held_a), 0);
        check("async_reset_hold_ticks", int'(hold_a), 0);
        check("async_reset_pulses", int'({press_a, release_a, short_a, long_a, repeat_a}), 0);
        check("pending_before_reset", q_a.size(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_press(0, 10, 4);   // press on the first clock after reset release

        // Narrow counter saturates at 7, long fires once
        run_press(1, 50, 4);

        check("final_pending_a", q_a.size(), 0);
        check("final_pending_s", q_s.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
